// File: rtl/lpc_cycle_fifo.sv
// LPC decoded-cycle capture FIFO: one record per rising edge of in_clock_enable.
// Optional macro LPC_CYCLE_FIFO_IO_ONLY_EN keeps only IO cycles (cyctype[3:2]==0).
module lpc_cycle_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          lpc_clock,
    input  logic          reset,
    input  logic [3:0]    in_cyctype_dir,
    input  logic [31:0]   in_addr,
    input  logic [7:0]    in_data,
    input  logic          in_sync_timeout,
    input  logic          in_clock_enable,
    output logic [47:0]   out_record,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW:0]   out_count,
    output logic          out_overflow,
    output logic [7:0]    out_drop_count
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [47:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          ce_q;
    logic          drop_pending;
    logic          overflow;
    logic [7:0]    drop_count;

    logic          cyc_ok;
    logic          capture;
    logic          full;
    logic          pop;
    logic          wr_en;
    logic          drop;
    logic [47:0]   wr_record;

`ifdef LPC_CYCLE_FIFO_IO_ONLY_EN
    assign cyc_ok = (in_cyctype_dir[3:2] == 2'b00);
`else
    assign cyc_ok = 1'b1;
`endif

    // Edge detect on the completion level; history resets high so a
    // level already asserted at reset release is ignored.
    assign capture = in_clock_enable & ~ce_q & cyc_ok;
    assign full    = (count == FULL_CNT);
    assign pop     = out_valid & out_ready;
    assign wr_en   = capture & (~full | pop);
    assign drop    = capture & full & ~pop;

    assign wr_record = {in_cyctype_dir, in_addr, in_data,
                        2'b00, drop_pending, in_sync_timeout};

    always_ff @(posedge lpc_clock or posedge reset) begin
        if (reset) begin
            ce_q <= 1'b1;
        end else begin
            ce_q <= in_clock_enable;
        end
    end

    always_ff @(posedge lpc_clock) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_record;
        end
    end

    always_ff @(posedge lpc_clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge lpc_clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else begin
            unique case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Drop bookkeeping; pending is consumed by the next stored record.
    always_ff @(posedge lpc_clock or posedge reset) begin
        if (reset) begin
            drop_pending <= 1'b0;
            overflow     <= 1'b0;
            drop_count   <= '0;
        end else if (drop) begin
            drop_pending <= 1'b1;
            overflow     <= 1'b1;
            if (drop_count != 8'hFF) begin
                drop_count <= drop_count + 1'b1;
            end
        end else if (wr_en) begin
            drop_pending <= 1'b0;
        end
    end

    assign out_record     = mem[rd_ptr];
    assign out_valid      = (count != '0);
    assign out_count      = count;
    assign out_overflow   = overflow;
    assign out_drop_count = drop_count;

endmodule

// File: tb/tb_lpc_cycle_fifo.sv
// Randomized bench for lpc_cycle_fifo against a queue-based reference model.
// Build with +define+LPC_CYCLE_FIFO_IO_ONLY_EN to exercise the IO-only filter.
module tb_lpc_cycle_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          lpc_clock;
    logic          reset;
    logic [3:0]    in_cyctype_dir;
    logic [31:0]   in_addr;
    logic [7:0]    in_data;
    logic          in_sync_timeout;
    logic          in_clock_enable;
    logic [47:0]   out_record;
    logic          out_valid;
    logic          out_ready;
    logic [AW:0]   out_count;
    logic          out_overflow;
    logic [7:0]    out_drop_count;

    int errors = 0;
    int checks = 0;

    logic [47:0] m_q[$];
    int          m_drops;
    bit          m_ovf;
    bit          m_pend;
    bit          m_prev;

    lpc_cycle_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .lpc_clock       (lpc_clock),
        .reset           (reset),
        .in_cyctype_dir  (in_cyctype_dir),
        .in_addr         (in_addr),
        .in_data         (in_data),
        .in_sync_timeout (in_sync_timeout),
        .in_clock_enable (in_clock_enable),
        .out_record      (out_record),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_count       (out_count),
        .out_overflow    (out_overflow),
        .out_drop_count  (out_drop_count)
    );

    initial begin
        lpc_clock = 1'b0;
        forever #5 lpc_clock = ~lpc_clock;
    end

    task automatic model_reset();
        m_q.delete();
        m_drops = 0;
        m_ovf   = 1'b0;
        m_pend  = 1'b0;
        m_prev  = 1'b1;
    endtask

    // Advance the reference model by one clock, then the DUT.
    task automatic step();
        bit cap;
        bit pop;
        bit full;
        if (reset) begin
            model_reset();
        end else begin
            cap = in_clock_enable && !m_prev;
`ifdef LPC_CYCLE_FIFO_IO_ONLY_EN
            if (in_cyctype_dir[3:2] != 2'b00) cap = 1'b0;
`endif
            full = (m_q.size() == DEPTH);
            pop  = (m_q.size() != 0) && out_ready;
            if (pop) void'(m_q.pop_front());
            if (cap) begin
                if (!full || pop) begin
                    m_q.push_back({in_cyctype_dir, in_addr, in_data,
                                   2'b00, m_pend, in_sync_timeout});
                    m_pend = 1'b0;
                end else begin
                    if (m_drops < 255) m_drops++;
                    m_ovf  = 1'b1;
                    m_pend = 1'b1;
                end
            end
            m_prev = in_clock_enable;
        end
        @(posedge lpc_clock);
        #1;
    endtask

    task automatic capture_one(input logic [3:0] cyc);
        in_clock_enable = 1'b0;
        step();
        in_cyctype_dir  = cyc;
        in_addr         = $urandom;
        in_data         = 8'($urandom);
        in_sync_timeout = 1'($urandom);
        in_clock_enable = 1'b1;
        step();
    endtask

    task automatic drain_checked(input string name);
        out_ready       = 1'b1;
        in_clock_enable = 1'b0;
        for (int i = 0; i < 2 * DEPTH && m_q.size() != 0; i++) begin
            checks++;
            if (out_record !== m_q[0]) begin
                errors++;
                $display("FAIL %s order: got %h want %h", name, out_record, m_q[0]);
            end
            step();
        end
        out_ready = 1'b0;
        checks++;
        if (out_count !== 0) begin
            errors++;
            $display("FAIL %s drained count: got %0d want 0", name, out_count);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (out_count !== 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: count=%0d valid=%b want 0/0", out_count, out_valid);
        end
        checks++;
        if (out_overflow !== 1'b0 || out_drop_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_flags: ovf=%b drops=%0d want 0/0", out_overflow, out_drop_count);
        end
        @(posedge lpc_clock);
        #1;
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (out_count !== 0) begin
            errors++;
            $display("FAIL reset_release_high: count=%0d want 0", out_count);
        end
    endtask

    task automatic test_io_write();
        logic [47:0] first;
        in_clock_enable = 1'b0;
        step();
        in_cyctype_dir  = 4'b0010;
        in_addr         = 32'h0000_0080;
        in_data         = 8'h5A;
        in_sync_timeout = 1'b0;
        in_clock_enable = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b1 || out_record !== 48'h2000000805A0) begin
            errors++;
            $display("FAIL io_write: valid=%b rec=%h want 1/2000000805a0", out_valid, out_record);
        end
        first = out_record;
        in_addr = $urandom;
        step();
        step();
        checks++;
        if (out_record !== first) begin
            errors++;
            $display("FAIL io_stall_stable: rec=%h want %h", out_record, first);
        end
        drain_checked("io_write");
    endtask

    task automatic test_held_high();
        in_clock_enable = 1'b0;
        step();
        in_cyctype_dir  = 4'b0011;
        in_clock_enable = 1'b1;
        for (int i = 0; i < 10; i++) step();
        checks++;
        if (out_count !== 1) begin
            errors++;
            $display("FAIL held_high: count=%0d want 1", out_count);
        end
        drain_checked("held_high");
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) capture_one(4'b0010);
        checks++;
        if (out_count !== DEPTH || out_drop_count !== 8'd4 || out_overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow: count=%0d drops=%0d ovf=%b want 16/4/1",
                     out_count, out_drop_count, out_overflow);
        end
        checks++;
        if (out_record[1] !== 1'b0) begin
            errors++;
            $display("FAIL overflow_head_flag: bit1=%b want 0", out_record[1]);
        end
        drain_checked("overflow");
        capture_one(4'b0010);
        checks++;
        if (out_record[3:1] !== 3'b001) begin
            errors++;
            $display("FAIL after_drop_flags: flags=%b want 001x", out_record[3:0]);
        end
        drain_checked("after_drop");
        capture_one(4'b0010);
        checks++;
        if (out_record[1] !== 1'b0) begin
            errors++;
            $display("FAIL pending_cleared: bit1=%b want 0", out_record[1]);
        end
        drain_checked("pending_clear");
    endtask

    task automatic test_full_pop();
        logic [7:0] drops_before;
        for (int i = 0; i < DEPTH; i++) capture_one(4'b0010);
        drops_before    = out_drop_count;
        in_clock_enable = 1'b0;
        step();
        in_cyctype_dir  = 4'b0011;
        in_addr         = $urandom;
        in_clock_enable = 1'b1;
        out_ready       = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (out_count !== DEPTH || out_drop_count !== drops_before) begin
            errors++;
            $display("FAIL full_pop: count=%0d drops=%0d want 16/%0d",
                     out_count, out_drop_count, drops_before);
        end
        drain_checked("full_pop");
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < DEPTH + 1; i++) capture_one(4'b0010);
        out_ready       = 1'b1;
        in_clock_enable = 1'b1;
        for (int i = 0; i < DEPTH - 5; i++) step();
        out_ready = 1'b0;
        checks++;
        if (out_count !== 5) begin
            errors++;
            $display("FAIL reset_mid_setup: count=%0d want 5", out_count);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (out_count !== 0 || out_valid !== 1'b0 || out_drop_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_async: count=%0d valid=%b drops=%0d want 0/0/0",
                     out_count, out_valid, out_drop_count);
        end
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) step();
        checks++;
        if (out_count !== 0) begin
            errors++;
            $display("FAIL reset_no_capture: count=%0d want 0", out_count);
        end
        capture_one(4'b0010);
        checks++;
        if (out_count !== 1 || out_record[1] !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_capture: count=%0d bit1=%b want 1/0",
                     out_count, out_record[1]);
        end
        drain_checked("reset_mid");
    endtask

    task automatic test_mem_cycle();
        int exp_cnt;
`ifdef LPC_CYCLE_FIFO_IO_ONLY_EN
        exp_cnt = 0;
`else
        exp_cnt = 1;
`endif
        capture_one(4'b0100);
        checks++;
        if (out_count !== exp_cnt || out_drop_count !== 8'(m_drops)) begin
            errors++;
            $display("FAIL mem_cycle: count=%0d drops=%0d want %0d/%0d",
                     out_count, out_drop_count, exp_cnt, m_drops);
        end
        drain_checked("mem_cycle");
    endtask

    task automatic test_random();
        int rdy_pct;
        for (int i = 0; i < 600; i++) begin
            rdy_pct = ((i / 100) % 2 == 0) ? 15 : 70;
            in_cyctype_dir  = 4'($urandom);
            in_addr         = $urandom;
            in_data         = 8'($urandom);
            in_sync_timeout = 1'($urandom);
            in_clock_enable = 1'($urandom);
            out_ready       = ($urandom_range(99) < rdy_pct);
            step();
            checks++;
            if (out_count !== m_q.size() || out_valid !== (m_q.size() != 0)) begin
                errors++;
                $display("FAIL random_count[%0d]: count=%0d valid=%b want %0d",
                         i, out_count, out_valid, m_q.size());
            end
            checks++;
            if (out_overflow !== m_ovf || out_drop_count !== 8'(m_drops)) begin
                errors++;
                $display("FAIL random_drop[%0d]: ovf=%b drops=%0d want %b/%0d",
                         i, out_overflow, out_drop_count, m_ovf, m_drops);
            end
            if (m_q.size() != 0) begin
                checks++;
                if (out_record !== m_q[0]) begin
                    errors++;
                    $display("FAIL random_head[%0d]: rec=%h want %h", i, out_record, m_q[0]);
                end
            end
        end
        out_ready = 1'b0;
        drain_checked("random");
    endtask

    initial begin
        reset           = 1'b1;
        in_cyctype_dir  = '0;
        in_addr         = '0;
        in_data         = '0;
        in_sync_timeout = 1'b0;
        in_clock_enable = 1'b1;
        out_ready       = 1'b0;
        model_reset();
        test_reset();
        test_io_write();
        test_held_high();
        test_overflow();
        test_full_pop();
        test_reset_mid();
        test_mem_cycle();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lpc_cycle_fifo.md
LPC_CYCLE_FIFO -- requirements
Module: lpc_cycle_fifo

Interface
REQ-001 Parameter DEPTH, default 16, FIFO entries; power of two, 4..64.
REQ-002 Parameter AW, default 4, pointer width; equals log2(DEPTH).
REQ-003 lpc_clock  input  1  sole clock; all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_cyctype_dir  input  4  cycle type/direction from the LPC decoder.
REQ-006 in_addr  input  32  decoded address.
REQ-007 in_data  input  8  decoded data byte.
REQ-008 in_sync_timeout  input  1  decoder sync-timeout flag.
REQ-009 in_clock_enable  input  1  decoder completion level; rises when a cycle completes, held until the next START.
REQ-010 out_record  output  48  head record: [47:44] cyctype_dir, [43:12] addr, [11:4] data, [3:0] flags.
REQ-011 out_valid  output  1  head record present.
REQ-012 out_ready  input  1  consumer accepts head when out_valid=1.
REQ-013 out_count  output  AW+1  entries stored, 0..DEPTH.
REQ-014 out_overflow  output  1  sticky: at least one record dropped since reset.
REQ-015 out_drop_count  output  8  dropped records, saturating at 255.

Function
REQ-016 Capture event SHALL be in_clock_enable=1 in cycle N while its registered previous value was 0; in_cyctype_dir, in_addr, in_data and in_sync_timeout are sampled in cycle N.
REQ-017 A held-high in_clock_enable SHALL produce exactly one capture; a new capture SHALL require a 0 then 1 transition.
REQ-018 Flags SHALL be: bit0 = in_sync_timeout; bit1 = one or more records dropped since the previous stored record; bits 3:2 = 0.
REQ-019 The drop-pending bit behind flag bit1 SHALL clear when a record carrying bit1=1 is written.
REQ-020 A capture with count<DEPTH SHALL be written at the end of cycle N; out_valid SHALL be 1 in cycle N+1 if the FIFO was empty (one-cycle latency).
REQ-021 Pop SHALL occur on a cycle with out_valid=1 and out_ready=1; out_ready with out_valid=0 SHALL have no effect.
REQ-022 out_record SHALL be stable while out_valid=1 and out_ready=0.
REQ-023 Records SHALL leave the FIFO in capture order.
REQ-024 Capture with count=DEPTH and no pop in the same cycle SHALL be dropped: out_overflow set, out_drop_count incremented (saturating), drop-pending set.
REQ-025 Capture and pop in the same cycle at count=DEPTH SHALL store the capture; count SHALL stay DEPTH.
REQ-026 Capture and pop in the same cycle at 0<count<DEPTH SHALL leave count unchanged.
REQ-027 Pointers SHALL wrap modulo DEPTH; full/empty SHALL be derived from out_count, never from pointer equality alone.
REQ-028 out_valid SHALL equal (out_count != 0); out_record SHALL be don't-care when out_valid=0.

Reset
REQ-029 reset=1 SHALL immediately clear pointers, out_count, out_valid, out_overflow, out_drop_count and drop-pending, without waiting for a clock edge.
REQ-030 The in_clock_enable history register SHALL reset to 1, so a level already high at reset release is not captured.
REQ-031 Reset mid-operation SHALL discard all stored records; the first capture after release SHALL be stored with flags bit1=0.

Configuration
REQ-032 Macro LPC_CYCLE_FIFO_IO_ONLY_EN: when defined, captures with in_cyctype_dir[3:2] != 2'b00 SHALL be discarded, affecting no FIFO state, overflow or drop counter; when undefined, all captures SHALL be handled per REQ-016..REQ-028.

Verification
REQ-033 IO write cycle (cyctype 4'b0010, addr 0x00000080, data 0x5A) -> out_valid next cycle, out_record 0x2000000805A0.
REQ-034 in_clock_enable held high 10 cycles -> exactly one record, out_count=1.
REQ-035 20 captures, out_ready=0, DEPTH=16 -> out_count=16, out_drop_count=4, out_overflow=1; after draining, next capture has flags=4'b0010.
REQ-036 At count=16, capture with out_ready=1 in the same cycle -> stored, count stays 16, out_drop_count unchanged.
REQ-037 reset pulse with count=5 and in_clock_enable=1 -> count 0, out_valid 0, no capture after release until in_clock_enable toggles 0 then 1.
REQ-038 Macro defined, memory cycle cyctype 4'b0100 -> no record, counters unchanged; macro undefined -> stored.
